// File: rtl/intr_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl_param
// Description : Parametrised vectored interrupt controller. It latches rising
//               edges on N_IRQ request lines into pending bits, applies a
//               software mask, and tracks in-service channels so that only a
//               strictly higher-priority request can nest. A single irq line
//               goes to the core, and the winning vector is returned on inta.
//               Define ROTATE_PRIO_EN to enable rotating priority. In that
//               mode the channel after the last EOI'd one becomes highest.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_ctrl_param #(
    parameter int N_IRQ = 8,
    parameter int VEC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] intr,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             inta,
    input  logic             eoi,
    output logic             irq,
    output logic [VEC_W-1:0] vec,
    output logic             vec_valid,
    output logic             spurious,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             irq_q, irq_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             vec_valid_q, vec_valid_d;
    logic             spurious_q, spurious_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] in_service_q, in_service_d;
    logic [N_IRQ-1:0] intr_prev_q;

    logic [VEC_W-1:0] w_base;
    logic [N_IRQ-1:0] w_edge;
    logic             w_is_found;
    logic [VEC_W-1:0] w_is_idx;
    int               w_is_rank;
    logic [N_IRQ-1:0] w_eligible;
    logic             w_win_found;
    logic [VEC_W-1:0] w_win_idx;
    logic [N_IRQ-1:0] w_eoi_clr;
    logic [N_IRQ-1:0] w_ack_set;

    // Channel holding priority rank k when the highest-priority channel is base
    function automatic logic [VEC_W-1:0] rot_idx(input logic [VEC_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_IRQ) s = s - N_IRQ;
        return VEC_W'(s);
    endfunction

`ifdef ROTATE_PRIO_EN
    logic [VEC_W-1:0] base_q, base_d;

    // The channel following the one just retired becomes highest priority
    always_comb begin
        base_d = base_q;
        if (eoi && w_is_found) base_d = rot_idx(w_is_idx, 1);
    end

    // Rotation base register
    always_ff @(posedge clk) begin
        if (reset) base_q <= '0;
        else       base_q <= base_d;
    end

    assign w_base = base_q;
`else
    assign w_base = '0;
`endif

    assign w_edge = intr & ~intr_prev_q;

    // Priority resolution: top in-service channel, nesting-limited eligible set, winner
    always_comb begin
        w_is_found  = 1'b0;
        w_is_idx    = '0;
        w_is_rank   = N_IRQ;
        w_eligible  = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_eoi_clr   = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (!w_is_found && in_service_q[rot_idx(w_base, k)]) begin
                w_is_found = 1'b1;
                w_is_idx   = rot_idx(w_base, k);
                w_is_rank  = k;
            end
        end
        // Only ranks strictly above the top in-service channel may interrupt
        for (int k = 0; k < N_IRQ; k++) begin
            if (k < w_is_rank)
                w_eligible[rot_idx(w_base, k)] = pending_q[rot_idx(w_base, k)]
                                                & ~mask_q[rot_idx(w_base, k)];
        end
        for (int k = 0; k < N_IRQ; k++) begin
            if (!w_win_found && w_eligible[rot_idx(w_base, k)]) begin
                w_win_found = 1'b1;
                w_win_idx   = rot_idx(w_base, k);
            end
        end
        if (eoi && w_is_found) w_eoi_clr[w_is_idx] = 1'b1;
    end

    // Request/acknowledge sequencing and next values of the bookkeeping registers
    always_comb begin
        state_d     = state_q;
        irq_d       = irq_q;
        vec_d       = vec_q;
        vec_valid_d = 1'b0;
        spurious_d  = 1'b0;
        w_ack_set   = '0;
        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (|w_eligible) begin
                    state_d = ST_REQ;
                    irq_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (inta) begin
                    state_d     = ST_ACK;
                    irq_d       = 1'b0;
                    vec_valid_d = 1'b1;
                    if (w_win_found) begin
                        vec_d                = w_win_idx;
                        w_ack_set[w_win_idx] = 1'b1;
                    end else begin
                        vec_d      = '1;
                        spurious_d = 1'b1;
                    end
                end else if (!(|w_eligible)) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
        // A new edge wins over an acknowledge of the same bit
        pending_d    = (pending_q & ~w_ack_set) | w_edge;
        in_service_d = (in_service_q & ~w_eoi_clr) | w_ack_set;
        mask_d       = mask_we ? mask_wdata : mask_q;
    end

    // State registers; lines already high at reset are not treated as edges
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            vec_q        <= '0;
            vec_valid_q  <= 1'b0;
            spurious_q   <= 1'b0;
            mask_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            intr_prev_q  <= intr;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            vec_q        <= vec_d;
            vec_valid_q  <= vec_valid_d;
            spurious_q   <= spurious_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            intr_prev_q  <= intr;
        end
    end

    assign irq        = irq_q;
    assign vec        = vec_q;
    assign vec_valid  = vec_valid_q;
    assign spurious   = spurious_q;
    assign mask       = mask_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_ctrl_param
// Description : Self-checking bench for intr_ctrl_param (N_IRQ=8, VEC_W=3).
//               Acks are scored through an expected-vector queue. The
//               rotation case is built only when ROTATE_PRIO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl_param;

    localparam int N  = 8;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  intr;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic          inta;
    logic          eoi;
    logic          irq;
    logic [VW-1:0] vec;
    logic          vec_valid;
    logic          spurious;
    logic [N-1:0]  mask;
    logic [N-1:0]  pending;
    logic [N-1:0]  in_service;

    always #5 clk = ~clk;

    intr_ctrl_param #(.N_IRQ(N), .VEC_W(VW)) dut (
        .clk        (clk),
        .reset      (reset),
        .intr       (intr),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .inta       (inta),
        .eoi        (eoi),
        .irq        (irq),
        .vec        (vec),
        .vec_valid  (vec_valid),
        .spurious   (spurious),
        .mask       (mask),
        .pending    (pending),
        .in_service (in_service)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [VW-1:0] v;
        logic          s;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [N-1:0]  pulse;
        logic          irq;
        logic [VW-1:0] v;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every vec_valid strobe must match the oldest expected ack
    always @(negedge clk) begin
        exp_t e;
        if (vec_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: vec_valid with vec=%0d, no ack expected", vec);
            end else begin
                e = sb.pop_front();
                chk("sb_vec", 32'(vec), 32'(e.v));
                chk("sb_spurious", 32'(spurious), 32'(e.s));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] held);
        reset = 1'b1; intr = held; inta = 1'b0; eoi = 1'b0; mask_we = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic set_mask(input logic [N-1:0] m);
        mask_we = 1'b1; mask_wdata = m;
        cyc();
        mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] p);
        intr = p;
        cyc();
        intr = '0;
    endtask

    task automatic wait_irq(input string name);
        int i = 0;
        while (irq !== 1'b1 && i < 20) begin
            cyc();
            i++;
        end
        chk(name, 32'(irq), 32'd1);
    endtask

    task automatic ack(input logic [VW-1:0] v, input logic s);
        exp_t e;
        e.v = v;
        e.s = s;
        sb.push_back(e);
        inta = 1'b1;
        cyc();
        inta = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        cyc();
        eoi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] oh;

        //                mask   pulse  irq   vec
        tbl[0] = '{8'h00, 8'h01, 1'b1, 3'd0};
        tbl[1] = '{8'h00, 8'h80, 1'b1, 3'd7};
        tbl[2] = '{8'h00, 8'h28, 1'b1, 3'd3};
        tbl[3] = '{8'h01, 8'h09, 1'b1, 3'd3};
        tbl[4] = '{8'hFF, 8'h10, 1'b0, 3'd0};
        tbl[5] = '{8'h0F, 8'hF0, 1'b1, 3'd4};
        tbl[6] = '{8'h00, 8'h00, 1'b0, 3'd0};
        tbl[7] = '{8'h40, 8'hC0, 1'b1, 3'd7};

        mask_wdata = '0;
        do_reset('0);
        chk("rst_irq",        32'(irq),        32'd0);
        chk("rst_vec",        32'(vec),        32'd0);
        chk("rst_vec_valid",  32'(vec_valid),  32'd0);
        chk("rst_spurious",   32'(spurious),   32'd0);
        chk("rst_mask",       32'(mask),       32'd0);
        chk("rst_pending",    32'(pending),    32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);

        // Table: mask + pulse -> exact latency and first winner
        for (int i = 0; i < 8; i++) begin
            do_reset('0);
            if (tbl[i].mask != '0) set_mask(tbl[i].mask);
            intr = tbl[i].pulse;
            cyc();
            intr = '0;
            chk($sformatf("t%0d_pend_latch", i), 32'(pending), 32'(tbl[i].pulse));
            chk($sformatf("t%0d_irq_early", i), 32'(irq), 32'd0);
            cyc();
            chk($sformatf("t%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
            if (tbl[i].irq) begin
                oh = 8'b1 << tbl[i].v;
                ack(tbl[i].v, 1'b0);
                chk($sformatf("t%0d_pend_after", i), 32'(pending), 32'(tbl[i].pulse & ~oh));
                chk($sformatf("t%0d_insvc", i), 32'(in_service), 32'(oh));
            end
        end

        // All eight channels at once, serviced in priority order
        do_reset('0);
        intr = 8'hFF; cyc(); cyc(); intr = '0;
        for (int v = 0; v < 8; v++) begin
            wait_irq($sformatf("all_irq%0d", v));
            ack(VW'(v), 1'b0);
            do_eoi();
        end
        cyc();
        chk("all_pending_end", 32'(pending), 32'd0);
        chk("all_insvc_end",   32'(in_service), 32'd0);

        // Masked channel waits, then is serviced after unmasking
        do_reset('0);
        set_mask(8'h01);
        pulse(8'h09);
        wait_irq("mask_irq");
        ack(3'd3, 1'b0);
        do_eoi();
        chk("mask_pend_kept", 32'(pending), 32'h01);
        set_mask(8'h00);
        wait_irq("unmask_irq");
        ack(3'd0, 1'b0);
        do_eoi();
        chk("unmask_pending", 32'(pending), 32'd0);

        // Nesting: 5 in service blocks 6, admits 2
        do_reset('0);
        pulse(8'h20);
        wait_irq("nest_irq5");
        ack(3'd5, 1'b0);
        pulse(8'h40);
        cyc(); cyc(); cyc();
        chk("nest_blocked_irq",  32'(irq),     32'd0);
        chk("nest_blocked_pend", 32'(pending), 32'h40);
        pulse(8'h04);
        wait_irq("nest_irq2");
        ack(3'd2, 1'b0);
        chk("nest_insvc_both", 32'(in_service), 32'h24);
        do_eoi();
        chk("nest_eoi1", 32'(in_service), 32'h20);
        cyc(); cyc();
        chk("nest_still_blocked", 32'(irq), 32'd0);
        do_eoi();
        chk("nest_eoi2", 32'(in_service), 32'h00);
        wait_irq("nest_irq6");
        ack(3'd6, 1'b0);
        do_eoi();
        chk("nest_done", 32'(in_service), 32'h00);

        // Masking withdraws irq; ack with nothing eligible is spurious
        do_reset('0);
        pulse(8'h10);
        wait_irq("drop_irq4");
        set_mask(8'h10);
        cyc();
        chk("drop_irq", 32'(irq), 32'd0);
        chk("drop_pend", 32'(pending), 32'h10);
        set_mask(8'h00);
        wait_irq("spur_irq");
        set_mask(8'h10);
        ack(3'd7, 1'b1);
        chk("spur_insvc", 32'(in_service), 32'd0);
        chk("spur_pend",  32'(pending),    32'h10);
        chk("spur_irq",   32'(irq),        32'd0);
        cyc();
        chk("vec_hold", 32'(vec), 32'd7);

        // Lines high through reset are not edges
        do_reset(8'hFF);
        cyc(); cyc();
        intr = '0;
        cyc();
        chk("held_pending", 32'(pending), 32'd0);
        chk("held_irq",     32'(irq),     32'd0);

        // Reset while in ACK discards the acknowledge
        pulse(8'h02);
        wait_irq("rstack_irq");
        ack(3'd1, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rstack_vec_valid", 32'(vec_valid),  32'd0);
        chk("rstack_insvc",     32'(in_service), 32'd0);
        chk("rstack_vec",       32'(vec),        32'd0);
        chk("rstack_irq",       32'(irq),        32'd0);

`ifdef ROTATE_PRIO_EN
        // After EOI of channel 0 the base moves to 1, so 3 outranks 0
        do_reset('0);
        pulse(8'h09);
        wait_irq("rot_irq0");
        ack(3'd0, 1'b0);
        do_eoi();
        pulse(8'h01);
        wait_irq("rot_irq3");
        ack(3'd3, 1'b0);
        do_eoi();
        wait_irq("rot_irq0b");
        ack(3'd0, 1'b0);
        do_eoi();
        chk("rot_pending", 32'(pending), 32'd0);
`endif

        cyc(); cyc(); cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intr_ctrl_param.md
Name: intr_ctrl_param

Overview:
- Parametrised, vectored interrupt controller between N external request lines and the single-cycle MIPS core's `intr`/`inta`/`vec` interrupt interface.
- Adds capabilities the fixed 8-line scheme lacks:
  - edge-latched pending bits
  - software mask register
  - in-service tracking with priority nesting
  - end-of-interrupt (EOI) input
  - optional rotating priority
- Drives a single `irq` request to the core and returns the winning channel's vector on acknowledge.

Parameters:
- N_IRQ, 8, number of request channels (2..32).
- VEC_W, 3, vector width; N_IRQ <= 2**VEC_W required.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- intr  in  N_IRQ  raw request lines, rising-edge sensitive
- mask_we  in  1  mask register write strobe
- mask_wdata  in  N_IRQ  new mask value (1 = channel masked)
- inta  in  1  acknowledge pulse from core (one cycle)
- eoi  in  1  non-specific end-of-interrupt pulse
- irq  out  1  interrupt request to core (registered)
- vec  out  VEC_W  vector of acknowledged channel
- vec_valid  out  1  one-cycle strobe, `vec` valid
- spurious  out  1  qualifies `vec_valid`: ack with no eligible request
- mask  out  N_IRQ  current mask register
- pending  out  N_IRQ  pending register
- in_service  out  N_IRQ  in-service register

Behaviour:
- Reset values:
  - pending=0, in_service=0, mask=0 (all enabled)
  - irq=0, vec=0, vec_valid=0, spurious=0
  - FSM=IDLE, rotation base=0
  - intr_prev loaded with `intr`, so lines held high through reset do not create edges.
- Edge capture: every cycle, `pending |= intr & ~intr_prev`; intr_prev <= intr.
  - Set wins over a same-cycle clear of the same bit.
- Mask: mask_we loads mask_wdata next edge. Masking never clears pending; a masked pending bit waits.
- Priority: index 0 highest (fixed mode).
- Eligible set = pending & ~mask & {channels of strictly higher priority than the highest-priority in_service bit}. If in_service=0, all channels qualify.
- Winner = highest-priority eligible channel, computed combinationally each cycle.
- FSM:
  - IDLE: irq=0. Eligible nonempty -> REQ; irq rises on the same edge.
  - REQ: irq=1. If inta=1:
    - Winner exists: vec<=winner, pending[winner]<=0, in_service[winner]<=1, vec_valid<=1, spurious<=0.
    - No winner: vec<=all ones, vec_valid<=1, spurious<=1, no register change.
    - In both cases irq<=0 and the FSM goes to ACK.
  - REQ, inta=0, eligible becomes empty (masked or nested): -> IDLE, irq<=0.
  - ACK: vec_valid and spurious held exactly one cycle, then cleared; -> IDLE. `vec` holds its last value.
  - inta outside REQ: ignored.
- Latency:
  - Edge on intr at cycle t -> pending at t+1 -> irq at t+2 (IDLE, unmasked, no nesting block).
  - inta at cycle t -> vec_valid high during t+1.
- EOI: clears the highest-priority set in_service bit next edge; no effect if in_service=0.
  - eoi and inta on the same cycle: `in_service <= (in_service & ~eoi_clr) | ack_set`, with eoi_clr computed from the pre-edge in_service.
- Nesting: a higher-priority request during service raises irq; lower or equal priority waits for EOI.
- Reset mid-operation (any state, incl. ACK): returns to reset values next edge; in-flight acks are discarded.

Optional Feature:
- Macro ROTATE_PRIO_EN.
- Defined:
  - Rotating priority. A base pointer (VEC_W bits, reset 0) names the highest-priority channel; priority descends as base, base+1, ... mod N_IRQ.
  - On every EOI that clears channel k, base <= (k+1) mod N_IRQ.
  - Winner and nesting comparisons use rotated order.
- Undefined: base fixed at 0; no rotation register is synthesised.

Test Plan:
- N_IRQ=8: reset, then intr 0x00->0xFF for 2 cycles, inta pulsed in each REQ cycle, eoi after each ack -> vec sequence 0,1,2,...,7, each with vec_valid=1, spurious=0; pending=0 at end.
- mask=0x01, pulse intr[0] and intr[3] -> vec=3; after mask=0x00, next ack gives vec=0.
- Channel 5 in service, pulse intr[6] -> irq stays 0. Pulse intr[2] -> irq=1, ack vec=2. eoi clears bit 2, second eoi clears bit 5, then channel 6 is acked.
- irq=1 for channel 4, mask written 0x10 before inta -> irq drops next cycle. inta pulse while the FSM is REQ with no eligible request -> vec=7, spurious=1.
- intr held 0xFF through reset, released -> no pending bits set. reset asserted during ACK -> vec_valid=0, in_service=0 next cycle.
- ROTATE_PRIO_EN: pending 0x09, ack vec=0, eoi (base->1), re-pulse intr[0] -> next ack vec=3 before vec=0.
